// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch/branch controller: opcodes, condition codes,
// PSR flag positions, FSM states and the decoded control payload.
package fetch_ctrl_pkg;

  localparam int unsigned IMMWIDTH = 8;
  localparam int unsigned CONDW    = 4;
  localparam int unsigned FLAGW    = 5;

  localparam logic [3:0] BCOND     = 4'hC;
  localparam logic [3:0] JCOND_OP  = 4'h4;
  localparam logic [3:0] JCOND_EXT = 4'hC;
  localparam logic [3:0] JAL_EXT   = 4'h8;

  localparam logic [CONDW-1:0] EQ = 4'h0;
  localparam logic [CONDW-1:0] NE = 4'h1;
  localparam logic [CONDW-1:0] CS = 4'h2;
  localparam logic [CONDW-1:0] CC = 4'h3;
  localparam logic [CONDW-1:0] HI = 4'h4;
  localparam logic [CONDW-1:0] LS = 4'h5;
  localparam logic [CONDW-1:0] GT = 4'h6;
  localparam logic [CONDW-1:0] LE = 4'h7;
  localparam logic [CONDW-1:0] FS = 4'h8;
  localparam logic [CONDW-1:0] FC = 4'h9;
  localparam logic [CONDW-1:0] LO = 4'hA;
  localparam logic [CONDW-1:0] HS = 4'hB;
  localparam logic [CONDW-1:0] LT = 4'hC;
  localparam logic [CONDW-1:0] GE = 4'hD;
  localparam logic [CONDW-1:0] UC = 4'hE;

  // PSR layout {C,L,F,Z,N}
  localparam int unsigned FLAG_C = 4;
  localparam int unsigned FLAG_L = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_STALL  = 3'd3,
    ST_UPDATE = 3'd4
  } state_e;

  typedef struct packed {
    logic take_br;
    logic take_j;
    logic is_jal;
  } ctl_t;

endpackage

// File: rtl/fetch_ctrl_cond_eval.sv
// Combinational branch-condition evaluator: condition code + PSR flags -> taken.
module fetch_ctrl_cond_eval
  import fetch_ctrl_pkg::*;
(
  input  logic [CONDW-1:0] cond,
  input  logic [FLAGW-1:0] flags,
  output logic             taken_c
);

  logic c, l, f, z, n;

  assign c = flags[FLAG_C];
  assign l = flags[FLAG_L];
  assign f = flags[FLAG_F];
  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];

  always_comb begin
    taken_c = 1'b0;
    case (cond)
      EQ:      taken_c = z;
      NE:      taken_c = !z;
      CS:      taken_c = c;
      CC:      taken_c = !c;
      HI:      taken_c = l;
      LS:      taken_c = !l;
      GT:      taken_c = n;
      LE:      taken_c = !n;
      FS:      taken_c = f;
      FC:      taken_c = !f;
      LO:      taken_c = !l && !z;
      HS:      taken_c = l || z;
      LT:      taken_c = !n && !z;
      GE:      taken_c = n || z;
      UC:      taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch / branch-control FSM driving the pc block one cycle per instruction.
// Define FETCH_TIMEOUT_EN to enable the fetch watchdog and sticky fetch_err.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned DW          = 16,
  parameter int unsigned TIMEOUT_CYC = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       pc,
  input  logic [DW-1:0]       pc_ra,
  output logic                mem_rd,
  output logic [DW-1:0]       mem_addr,
  input  logic                mem_rdy,
  input  logic [DW-1:0]       mem_data,
  input  logic [FLAGW-1:0]    flags,
  output logic [3:0]          rtgt_addr,
  input  logic [DW-1:0]       rtgt_data,
  input  logic                exe_busy,
  output logic [DW-1:0]       instr,
  output logic                instr_valid,
  output logic                pcEn,
  output logic                branch,
  output logic                jump,
  output logic [IMMWIDTH-1:0] disp,
  output logic [DW-1:0]       dDst,
  output logic                link_we,
  output logic [3:0]          link_addr,
  output logic [DW-1:0]       link_data,
  output logic                fetch_err
);

  state_e              state_q, state_d;
  logic [DW-1:0]       ir_q, tgt_q, tgt_use;
  ctl_t                ctl_q, ctl_live, ctl_use;
  logic                cond_taken_c, timeout_c;
  logic                mem_rd_d, instr_valid_d, pcen_d, branch_d, jump_d, link_we_d;
  logic [IMMWIDTH-1:0] disp_d;
  logic [DW-1:0]       ddst_d, link_data_d;

  assign mem_addr  = pc;
  assign instr     = ir_q;
  assign rtgt_addr = ir_q[3:0];
  assign link_addr = ir_q[11:8];

  fetch_ctrl_cond_eval u_cond (
    .cond    (ir_q[11:8]),
    .flags   (flags),
    .taken_c (cond_taken_c)
  );

  always_comb begin
    ctl_live         = '0;
    ctl_live.take_br = (ir_q[15:12] == BCOND) && cond_taken_c;
    ctl_live.take_j  = (ir_q[15:12] == JCOND_OP) && (ir_q[7:4] == JCOND_EXT) && cond_taken_c;
    ctl_live.is_jal  = (ir_q[15:12] == JCOND_OP) && (ir_q[7:4] == JAL_EXT);
  end

  // Leaving DECODE uses live flags/target; leaving STALL uses what DECODE sampled.
  assign ctl_use = (state_q == ST_DECODE) ? ctl_live  : ctl_q;
  assign tgt_use = (state_q == ST_DECODE) ? rtgt_data : tgt_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_q;
  logic          fetch_err_q;

  assign timeout_c = (state_q == ST_FETCH) && !mem_rdy && (to_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign fetch_err = fetch_err_q;

  // Counts consecutive unanswered FETCH cycles; zero whenever outside FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q    <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      if (state_q != ST_FETCH || mem_rdy) to_cnt_q <= '0;
      else                                to_cnt_q <= to_cnt_q + TW'(1);
      if (timeout_c) fetch_err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
  assign timeout_c          = 1'b0;
  assign fetch_err          = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    mem_rd_d      = 1'b0;
    instr_valid_d = 1'b0;
    pcen_d        = 1'b0;
    branch_d      = 1'b0;
    jump_d        = 1'b0;
    disp_d        = '0;
    ddst_d        = '0;
    link_we_d     = 1'b0;
    link_data_d   = '0;

    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (mem_rdy || timeout_c) state_d = ST_DECODE;
      ST_DECODE: state_d = exe_busy ? ST_STALL : ST_UPDATE;
      ST_STALL:  if (!exe_busy) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    mem_rd_d      = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_DECODE);
    if (state_d == ST_UPDATE) begin
      pcen_d      = 1'b1;
      branch_d    = ctl_use.take_br;
      disp_d      = ctl_use.take_br ? ir_q[IMMWIDTH-1:0] : '0;
      jump_d      = ctl_use.take_j || ctl_use.is_jal;
      ddst_d      = (ctl_use.take_j || ctl_use.is_jal) ? tgt_use : '0;
      link_we_d   = ctl_use.is_jal;
      link_data_d = pc_ra;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      ctl_q       <= '0;
      tgt_q       <= '0;
      mem_rd      <= 1'b0;
      instr_valid <= 1'b0;
      pcEn        <= 1'b0;
      branch      <= 1'b0;
      jump        <= 1'b0;
      disp        <= '0;
      dDst        <= '0;
      link_we     <= 1'b0;
      link_data   <= '0;
    end else begin
      state_q     <= state_d;
      if (state_q == ST_FETCH) begin
        if (mem_rdy)        ir_q <= mem_data;
        else if (timeout_c) ir_q <= '0;
      end
      if (state_q == ST_DECODE) begin
        ctl_q <= ctl_live;
        tgt_q <= rtgt_data;
      end
      mem_rd      <= mem_rd_d;
      instr_valid <= instr_valid_d;
      pcEn        <= pcen_d;
      branch      <= branch_d;
      jump        <= jump_d;
      disp        <= disp_d;
      dDst        <= ddst_d;
      link_we     <= link_we_d;
      link_data   <= link_data_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a behavioural pc block and register-file port.
// Exercises the FETCH_TIMEOUT_EN watchdog when that macro is defined.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] pc, pc_ra, mem_addr, mem_data, rtgt_data, instr, dDst, link_data;
  logic          mem_rd, mem_rdy, exe_busy, instr_valid, pcEn, branch, jump, link_we, fetch_err;
  logic [4:0]    flags;
  logic [3:0]    rtgt_addr, link_addr;
  logic [7:0]    disp;
  logic [3:0]    tgt_reg;
  logic [15:0]   tgt_val;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] ins;
    logic [4:0]  flg;
    logic [3:0]  treg;
    logic [15:0] tval;
    logic        br;
    logic        jp;
    logic [7:0]  dsp;
    logic [15:0] dst;
    logic        lwe;
    logic [15:0] npc;
  } vec_t;

  typedef struct {
    logic [15:0] ins;
    logic        br;
    logic        jp;
    logic [7:0]  dsp;
    logic [15:0] dst;
    logic        lwe;
    logic [3:0]  laddr;
    logic [15:0] ldata;
    logic [15:0] npc;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];

  fetch_ctrl #(.DW(16), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_ra(pc_ra),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_data(mem_data),
    .flags(flags), .rtgt_addr(rtgt_addr), .rtgt_data(rtgt_data), .exe_busy(exe_busy),
    .instr(instr), .instr_valid(instr_valid), .pcEn(pcEn), .branch(branch), .jump(jump),
    .disp(disp), .dDst(dDst), .link_we(link_we), .link_addr(link_addr),
    .link_data(link_data), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Behavioural pc block: branch adds sign-extended disp, jump loads dDst, else +1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else if (pcEn) begin
      if (jump)        pc <= dDst;
      else if (branch) pc <= pc + {{8{disp[7]}}, disp};
      else             pc <= pc + 16'd1;
    end
  end
  assign pc_ra     = pc + 16'd1;
  assign rtgt_data = (rtgt_addr == tgt_reg) ? tgt_val : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e, got;
    int   fetch_cyc, done;
    logic prev_iv;
    mem_data = v.ins; flags = v.flg; tgt_reg = v.treg; tgt_val = v.tval;
    mem_rdy  = 1'b1;  exe_busy = 1'b0;
    e = '{v.ins, v.br, v.jp, v.dsp, v.dst, v.lwe, v.ins[11:8], pc + 16'd1, v.npc};
    sb.push_back(e);
    got = e;
    fetch_cyc = -1; done = 0; prev_iv = 1'b0;
    for (int c = 0; c < 20 && done == 0; c++) begin
      @(negedge clk);
      if (mem_rd && fetch_cyc < 0) begin
        fetch_cyc = c;
        check("mem_addr", 32'(mem_addr), 32'(pc));
      end
      if (pcEn) begin
        got = sb.pop_front();
        check("instr",     32'(instr),     32'(got.ins));
        check("branch",    32'(branch),    32'(got.br));
        check("jump",      32'(jump),      32'(got.jp));
        check("disp",      32'(disp),      32'(got.dsp));
        check("dDst",      32'(dDst),      32'(got.dst));
        check("link_we",   32'(link_we),   32'(got.lwe));
        check("link_addr", 32'(link_addr), 32'(got.laddr));
        check("link_data", 32'(link_data), 32'(got.ldata));
        check("iv_before_pcen", 32'(prev_iv), 32'd1);
        check("latency", 32'(c - fetch_cyc), 32'd2);
        done = 1;
      end
      prev_iv = instr_valid;
    end
    if (done == 0) begin
      check("pcen_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(posedge clk); #1;
    check("pcen_one_cycle", 32'(pcEn), 32'd0);
    check("pc_next", 32'(pc), 32'(got.npc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int rd_cnt, pcen_cnt, pcen_at, err_cnt;
    logic [15:0] instr_at_en, ddst_at_en;
    logic jump_at_en;

    //             ins       flg       treg  tval      br    jp    dsp    dst       lwe   npc
    vecs[0]  = '{16'h0000, 5'b00000, 4'h0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0001};
    vecs[1]  = '{16'hC07F, 5'b00000, 4'hF, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0002};
    vecs[2]  = '{16'hC0FF, 5'b00010, 4'hF, 16'h0000, 1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h0001};
    vecs[3]  = '{16'hC07F, 5'b00010, 4'hF, 16'h0000, 1'b1, 1'b0, 8'h7F, 16'h0000, 1'b0, 16'h0080};
    vecs[4]  = '{16'hCA81, 5'b00000, 4'h1, 16'h0000, 1'b1, 1'b0, 8'h81, 16'h0000, 1'b0, 16'h0001};
    vecs[5]  = '{16'h4EC5, 5'b00000, 4'h5, 16'h8000, 1'b0, 1'b1, 8'h00, 16'h8000, 1'b0, 16'h8000};
    vecs[6]  = '{16'h4E83, 5'b00000, 4'h3, 16'hFFFF, 1'b0, 1'b1, 8'h00, 16'hFFFF, 1'b1, 16'hFFFF};
    vecs[7]  = '{16'h4FC5, 5'b00000, 4'h5, 16'h1234, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000};
    vecs[8]  = '{16'hC40A, 5'b01000, 4'hA, 16'h0000, 1'b1, 1'b0, 8'h0A, 16'h0000, 1'b0, 16'h000A};
    vecs[9]  = '{16'hCD05, 5'b00000, 4'h5, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h000B};
    vecs[10] = '{16'h4CC2, 5'b00000, 4'h2, 16'h0100, 1'b0, 1'b1, 8'h00, 16'h0100, 1'b0, 16'h0100};
    vecs[11] = '{16'h4E92, 5'b00000, 4'h2, 16'h5555, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0101};
    vecs[12] = '{16'hC203, 5'b10000, 4'h3, 16'h0000, 1'b1, 1'b0, 8'h03, 16'h0000, 1'b0, 16'h0104};
    vecs[13] = '{16'hC303, 5'b10000, 4'h3, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0105};
    vecs[14] = '{16'h4BC7, 5'b00010, 4'h7, 16'h0042, 1'b0, 1'b1, 8'h00, 16'h0042, 1'b0, 16'h0042};

    mem_rdy = 1'b0; mem_data = '0; flags = '0; exe_busy = 1'b0; tgt_reg = '0; tgt_val = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_rd",      32'(mem_rd),      32'd0);
    check("rst_pcEn",        32'(pcEn),        32'd0);
    check("rst_instr",       32'(instr),       32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_dDst",        32'(dDst),        32'd0);
    check("rst_link_we",     32'(link_we),     32'd0);
    check("rst_fetch_err",   32'(fetch_err),   32'd0);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Four wait states then two busy cycles; late mem_rdy/data and flag/target changes must be ignored.
    rd_cnt = 0; pcen_cnt = 0; pcen_at = -1;
    instr_at_en = '0; ddst_at_en = '0; jump_at_en = 1'b0;
    tgt_reg = 4'h5;
    for (int c = 0; c < 10; c++) begin
      mem_rdy  = (c >= 4 && c <= 8);
      mem_data = (c == 4) ? 16'h40C5 : 16'hC07F;
      exe_busy = (c == 5 || c == 6);
      flags    = (c <= 5) ? 5'b00010 : 5'b00000;
      tgt_val  = (c <= 5) ? 16'h0200 : 16'hBEEF;
      @(negedge clk);
      if (c <= 8 && mem_rd) rd_cnt++;
      if (pcEn) begin
        pcen_cnt++; pcen_at = c;
        instr_at_en = instr; ddst_at_en = dDst; jump_at_en = jump;
      end
      @(posedge clk); #1;
    end
    check("wait_mem_rd_cycles", 32'(rd_cnt),      32'd5);
    check("stall_pcen_count",   32'(pcen_cnt),    32'd1);
    check("stall_pcen_cycle",   32'(pcen_at),     32'd8);
    check("stall_instr",        32'(instr_at_en), 32'h40C5);
    check("stall_jump",         32'(jump_at_en),  32'd1);
    check("stall_dDst",         32'(ddst_at_en),  32'h0200);
    check("stall_pc",           32'(pc),          32'h0200);

    // Async reset while in STALL
    mem_data = 16'h0000; mem_rdy = 1'b1; exe_busy = 1'b1;
    @(posedge clk); #1;
    mem_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("arst_pcEn",        32'(pcEn),        32'd0);
    check("arst_mem_rd",      32'(mem_rd),      32'd0);
    check("arst_instr",       32'(instr),       32'd0);
    check("arst_instr_valid", 32'(instr_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("arst_hold_mem_rd", 32'(mem_rd), 32'd0);
    check("arst_pc",          32'(pc),     32'd0);
    exe_busy = 1'b0; mem_rdy = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

`ifdef FETCH_TIMEOUT_EN
    rd_cnt = 0; pcen_at = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c <= 8 && mem_rd) rd_cnt++;
      if (c == 7) check("to_err_before", 32'(fetch_err), 32'd0);
      if (c == 8) begin
        check("to_err_set", 32'(fetch_err), 32'd1);
        check("to_instr",   32'(instr),     32'd0);
      end
      if (pcEn && pcen_at < 0) pcen_at = c;
    end
    check("to_fetch_cycles", 32'(rd_cnt),  32'd8);
    check("to_pcen_cycle",   32'(pcen_at), 32'd9);
    @(posedge clk); #1;
    check("to_pc", 32'(pc), 32'h0001);
    repeat (5) @(negedge clk);
    check("to_err_sticky", 32'(fetch_err), 32'd1);
`else
    rd_cnt = 0; pcen_cnt = 0; err_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_rd)    rd_cnt++;
      if (pcEn)      pcen_cnt++;
      if (fetch_err) err_cnt++;
    end
    check("wait_forever_mem_rd", 32'(rd_cnt),   32'd20);
    check("wait_forever_pcen",   32'(pcen_cnt), 32'd0);
    check("wait_forever_err",    32'(err_cnt),  32'd0);
    check("wait_forever_pc",     32'(pc),       32'd0);
`endif

    rst = 1'b0;
    #1;
    check("final_rst_fetch_err", 32'(fetch_err), 32'd0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
